// File: rtl/ahb_lite_manager.sv
// ahb_lite_manager: single-command AHB-Lite manager driving NONSEQ/SEQ/BUSY/IDLE with wait-state and ERROR handling.
// Optional HMASTLOCK/cmd_lock ports are enabled by defining AHB_MGR_HMASTLOCK_EN.
module ahb_lite_manager #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_size,
    input  logic [2:0]        cmd_burst,
    input  logic [4:0]        cmd_len,
    input  logic              wvalid,
    input  logic [DATA_W-1:0] wdata,
    output logic              wready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              done_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP,
    input  logic [DATA_W-1:0] HRDATA
`ifdef AHB_MGR_HMASTLOCK_EN
    ,
    input  logic              cmd_lock,
    output logic              HMASTLOCK
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_trans;
    logic              r_write;
    logic [2:0]        r_size;
    logic [2:0]        r_burst;
    logic [4:0]        r_beats;
    logic              r_dph;
    logic [DATA_W-1:0] r_hwdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_done;
    logic              r_err;
    logic              w_busy;
    logic [1:0]        w_htrans;
    logic              w_xfer;
    logic              w_err1;
    logic              w_wrap;
    logic              w_cross;
    logic [4:0]        w_beats;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_next;
    // BUSY is substituted combinationally so an empty write stream stalls the burst without losing the beat
    assign w_busy   = (r_state == S_BURST) & r_write & ~wvalid;
    assign w_htrans = w_busy ? T_BUSY : r_trans;
    assign w_xfer   = w_htrans[1] & HREADY;
    assign w_err1   = r_dph & ~HREADY & (HRESP == 2'b01);
    assign w_wrap   = ~r_burst[0] & (r_burst != 3'b000);
    assign w_inc    = r_addr + (ADDR_W'(1) << r_size);
    assign w_mask   = (ADDR_W'(2) << ({1'b0, r_burst[2:1]} + r_size)) - ADDR_W'(1);
    assign w_next   = w_wrap ? ((r_addr & ~w_mask) | (w_inc & w_mask)) : w_inc;
    assign w_cross  = w_next[ADDR_W-1:10] != r_addr[ADDR_W-1:10];
    assign w_beats  = (cmd_burst == 3'b000) ? 5'd0 :
                      (cmd_burst == 3'b001) ? ((cmd_len == 5'd0) ? 5'd0 : cmd_len - 5'd1) :
                      (5'd2 << cmd_burst[2:1]) - 5'd1;
    assign cmd_ready = r_state == S_IDLE;
    assign wready    = w_xfer & r_write;
    assign rd_valid  = r_rvalid;
    assign rd_data   = r_rdata;
    assign done      = r_done;
    assign done_err  = r_err;
    assign HADDR     = r_addr;
    assign HTRANS    = w_htrans;
    assign HWRITE    = r_write;
    assign HSIZE     = r_size;
    assign HBURST    = r_burst;
    assign HWDATA    = r_hwdata;
`ifdef AHB_MGR_HMASTLOCK_EN
    logic r_lock;
    assign HMASTLOCK = r_lock & ((r_state == S_ADDR) | (r_state == S_BURST));
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_lock <= 1'b0;
        else if (r_state == S_IDLE && cmd_valid)
            r_lock <= cmd_lock;
    end
`endif
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_trans  <= T_IDLE;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_burst  <= '0;
            r_beats  <= '0;
            r_dph    <= 1'b0;
            r_hwdata <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rvalid <= 1'b0;
            if (r_dph && HREADY && !r_write && HRESP == 2'b00) begin
                r_rvalid <= 1'b1;
                r_rdata  <= HRDATA;
            end
            if (HREADY)
                r_dph <= w_xfer;
            if (w_xfer && r_write)
                r_hwdata <= wdata;
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_addr  <= cmd_addr;
                    r_write <= cmd_write;
                    r_size  <= cmd_size;
                    r_burst <= cmd_burst;
                    r_beats <= w_beats;
                    r_state <= (cmd_write && !wvalid) ? S_HOLD : S_ADDR;
                    r_trans <= (cmd_write && !wvalid) ? T_IDLE : T_NSEQ;
                end
                S_HOLD: if (wvalid) begin
                    r_state <= S_ADDR;
                    r_trans <= T_NSEQ;
                end
                S_ADDR, S_BURST: if (w_err1) begin
                    r_trans <= T_IDLE;
                    r_state <= S_ERR;
                end else if (w_xfer) begin
                    if (r_beats == 5'd0) begin
                        r_trans <= T_IDLE;
                        r_state <= S_LAST;
                    end else begin
                        r_addr  <= w_next;
                        r_trans <= w_cross ? T_NSEQ : T_SEQ;
                        r_beats <= r_beats - 5'd1;
                        r_state <= S_BURST;
                    end
                end
                S_LAST: if (w_err1) begin
                    r_state <= S_ERR;
                end else if (HREADY) begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_ERR: if (HREADY) begin
                    r_done  <= 1'b1;
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_lite_manager.sv
// tb_ahb_lite_manager: scenario tasks against an AHB subordinate model with read/write-data scoreboards.
module tb_ahb_lite_manager;
    localparam int AW = 32;
    localparam int DW = 32;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic cmd_valid = 1'b0, cmd_write = 1'b0;
    logic cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [2:0] cmd_size = '0, cmd_burst = '0;
    logic [4:0] cmd_len = '0;
    logic wvalid = 1'b0;
    logic wready;
    logic [DW-1:0] wdata = '0;
    logic rd_valid, done, done_err;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] HADDR;
    logic [1:0] HTRANS;
    logic HWRITE;
    logic [2:0] HSIZE, HBURST;
    logic [DW-1:0] HWDATA;
    logic HREADY = 1'b1;
    logic [1:0] HRESP = 2'b00;
    logic [DW-1:0] HRDATA = '0;

    always #5 HCLK = ~HCLK;

    ahb_lite_manager #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] c_addr;
    logic c_write;
    logic [2:0] c_size, c_burst;
    logic [4:0] c_len;
    logic [DW-1:0] wbase;
    int stall_beat, stall_n, err_beat, wgap_after, wgap_n;
    logic [1:0] tr_t[$];
    logic [1:0] act_t[$];
    logic [AW-1:0] act_a[$];
    logic [DW-1:0] exp_rd[$], act_rd[$], exp_hw[$], act_hw[$];
    int ix_nonseq, ix_err, ix_done, n_wready;
    logic got_done, done_e, rdy_at_done;

    task automatic cfg(input logic [AW-1:0] a, input logic w, input logic [2:0] s, input logic [2:0] b,
                       input logic [4:0] l, input logic [DW-1:0] wb);
        c_addr = a; c_write = w; c_size = s; c_burst = b; c_len = l; wbase = wb;
        stall_beat = -1; stall_n = 0; err_beat = -1; wgap_after = -1; wgap_n = 0;
    endtask

    // Presents the command now and plays the subordinate until done; all expectations are pushed here.
    task automatic run();
        int dbeat = 0;
        int pc = 0;
        int wcnt = 0;
        int gap = wgap_n;
        bit dph = 0;
        tr_t.delete(); act_t.delete(); act_a.delete();
        exp_rd.delete(); act_rd.delete(); exp_hw.delete(); act_hw.delete();
        ix_nonseq = -1; ix_err = -1; ix_done = -1; n_wready = 0; got_done = 0; done_e = 0; rdy_at_done = 0;
        cmd_addr = c_addr; cmd_write = c_write; cmd_size = c_size; cmd_burst = c_burst; cmd_len = c_len;
        cmd_valid = 1'b1;
        HREADY = 1'b1; HRESP = 2'b00;
        wvalid = !(wgap_after == 0 && gap > 0);
        wdata = wbase;
        for (int cyc = 0; cyc < 150 && !got_done; cyc++) begin
            @(posedge HCLK); #1;
            cmd_valid = 1'b0;
            if (dph && dbeat == err_beat) begin
                HRESP = 2'b01; HREADY = (pc >= 1);
            end else begin
                HRESP = 2'b00; HREADY = !(dph && dbeat == stall_beat && pc < stall_n);
            end
            HRDATA = $urandom;
            wvalid = !(wcnt == wgap_after && gap > 0);
            wdata = wbase + DW'(wcnt);
            #1;
            tr_t.push_back(HTRANS);
            if (HTRANS != 2'b00) begin
                act_t.push_back(HTRANS); act_a.push_back(HADDR);
                if (HTRANS == 2'b10 && ix_nonseq < 0) ix_nonseq = cyc;
            end
            if (wready) begin exp_hw.push_back(wdata); wcnt++; n_wready++; end
            if (!wvalid) gap--;
            if (dph && HREADY && c_write) act_hw.push_back(HWDATA);
            if (dph && HREADY && !c_write && HRESP == 2'b00) exp_rd.push_back(HRDATA);
            if (dph && !HREADY && HRESP == 2'b01 && ix_err < 0) ix_err = cyc;
            if (rd_valid) act_rd.push_back(rd_data);
            if (done) begin got_done = 1; ix_done = cyc; done_e = done_err; rdy_at_done = cmd_ready; end
            if (HTRANS[1] && HREADY) begin dph = 1; dbeat++; pc = 0; end
            else if (HREADY) dph = 0;
            else pc++;
        end
        if (!got_done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done, expected done within 150 cycles");
        end
    endtask

    task automatic test_reset();
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %b expected 00", HTRANS); end
        checks++; if (HADDR !== '0) begin errors++; $display("FAIL rst_haddr: got %h expected 0", HADDR); end
        checks++; if (HWDATA !== '0 || rd_data !== '0) begin errors++; $display("FAIL rst_data: got %h/%h expected 0/0", HWDATA, rd_data); end
        checks++; if ({HWRITE, HSIZE, HBURST} !== 7'd0) begin errors++; $display("FAIL rst_ctrl: got %b expected 0", {HWRITE, HSIZE, HBURST}); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if ({wready, rd_valid, done, done_err} !== 4'b0) begin errors++; $display("FAIL rst_strobes: got %b expected 0000", {wready, rd_valid, done, done_err}); end
    endtask

    task automatic test_single_write();
        cfg(32'h2, 1'b1, 3'd0, 3'b000, 5'd0, 32'd5);
        run();
        checks++; if (act_t.size() != 1 || act_t[0] !== 2'b10 || act_a[0] !== 32'h2) begin errors++; $display("FAIL single_addr: got %0d beats first %b@%h expected 1 NONSEQ@2", act_t.size(), act_t[0], act_a[0]); end
        checks++; if (act_hw.size() != 1 || act_hw[0] !== 32'd5) begin errors++; $display("FAIL single_hwdata: got %0d beats %h expected 1 beat 5", act_hw.size(), act_hw[0]); end
        checks++; if (n_wready != 1) begin errors++; $display("FAIL single_wready: got %0d expected 1", n_wready); end
        checks++; if (ix_done - ix_nonseq != 2) begin errors++; $display("FAIL single_done_lat: got %0d expected 2", ix_done - ix_nonseq); end
        checks++; if (done_e !== 1'b0) begin errors++; $display("FAIL single_done_err: got %b expected 0", done_e); end
    endtask

    task automatic test_incr4_write_busy();
        logic [1:0] et[6] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11};
        logic [AW-1:0] ea[6] = '{32'h10, 32'h14, 32'h18, 32'h18, 32'h18, 32'h1C};
        logic [DW-1:0] e, a;
        cfg(32'h10, 1'b1, 3'd2, 3'b011, 5'd0, 32'hA0);
        wgap_after = 2; wgap_n = 2;
        run();
        checks++; if (act_t.size() != 6) begin errors++; $display("FAIL busy_len: got %0d expected 6", act_t.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (act_t[i] !== et[i] || act_a[i] !== ea[i]) begin errors++; $display("FAIL busy_beat%0d: got %b@%h expected %b@%h", i, act_t[i], act_a[i], et[i], ea[i]); end
        end
        checks++; if (n_wready != 4) begin errors++; $display("FAIL busy_wready: got %0d expected 4", n_wready); end
        for (int i = 0; i < 4; i++) begin
            e = exp_hw.size() > 0 ? exp_hw.pop_front() : 'x;
            a = act_hw.size() > 0 ? act_hw.pop_front() : 'x;
            checks++; if (a !== e || e !== 32'hA0 + DW'(i)) begin errors++; $display("FAIL busy_hwdata%0d: got %h expected %h", i, a, 32'hA0 + DW'(i)); end
        end
    endtask

    task automatic test_wrap8_read();
        logic [AW-1:0] ea[8] = '{32'h34, 32'h38, 32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30};
        logic [DW-1:0] e, a;
        cfg(32'h34, 1'b0, 3'd2, 3'b100, 5'd0, 32'h0);
        run();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (act_a[i] !== ea[i] || act_t[i] !== (i == 0 ? 2'b10 : 2'b11)) begin errors++; $display("FAIL wrap_beat%0d: got %b@%h expected @%h", i, act_t[i], act_a[i], ea[i]); end
        end
        checks++; if (act_rd.size() != 8 || exp_rd.size() != 8) begin errors++; $display("FAIL wrap_rd_count: got %0d expected 8", act_rd.size()); end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            a = act_rd.size() > 0 ? act_rd.pop_front() : 'x;
            checks++; if (a !== e) begin errors++; $display("FAIL wrap_rd_data: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_incr4_read_stall();
        logic [AW-1:0] ea[6] = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h48, 32'h4C};
        logic [DW-1:0] e, a;
        cfg(32'h40, 1'b0, 3'd2, 3'b011, 5'd0, 32'h0);
        stall_beat = 2; stall_n = 2;
        run();
        checks++; if (act_t.size() != 6) begin errors++; $display("FAIL stall_len: got %0d expected 6", act_t.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (act_a[i] !== ea[i] || act_t[i] !== (i == 0 ? 2'b10 : 2'b11)) begin errors++; $display("FAIL stall_beat%0d: got %b@%h expected @%h", i, act_t[i], act_a[i], ea[i]); end
        end
        checks++; if (act_rd.size() != 4 || exp_rd.size() != 4) begin errors++; $display("FAIL stall_rd_count: got %0d expected 4", act_rd.size()); end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            a = act_rd.size() > 0 ? act_rd.pop_front() : 'x;
            checks++; if (a !== e) begin errors++; $display("FAIL stall_rd_data: got %h expected %h", a, e); end
        end
        checks++; if (done_e !== 1'b0) begin errors++; $display("FAIL stall_done_err: got %b expected 0", done_e); end
    endtask

    task automatic test_incr_1kb();
        logic [1:0] et[3] = '{2'b10, 2'b10, 2'b11};
        logic [AW-1:0] ea[3] = '{32'h3FC, 32'h400, 32'h404};
        cfg(32'h3FC, 1'b0, 3'd2, 3'b001, 5'd3, 32'h0);
        run();
        checks++; if (act_t.size() != 3) begin errors++; $display("FAIL kb_len: got %0d expected 3", act_t.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_t[i] !== et[i] || act_a[i] !== ea[i]) begin errors++; $display("FAIL kb_beat%0d: got %b@%h expected %b@%h", i, act_t[i], act_a[i], et[i], ea[i]); end
        end
    endtask

    task automatic test_error();
        logic [DW-1:0] e, a;
        cfg(32'h80, 1'b1, 3'd2, 3'b101, 5'd0, 32'hC0);
        err_beat = 3;
        run();
        checks++; if (ix_err < 0 || tr_t[ix_err + 1] !== 2'b00) begin errors++; $display("FAIL err_cancel: got htrans %b after error expected 00", tr_t[ix_err + 1]); end
        checks++; if (done_e !== 1'b1) begin errors++; $display("FAIL err_done_err: got %b expected 1", done_e); end
        checks++; if (act_t.size() != 4) begin errors++; $display("FAIL err_beats: got %0d expected 4", act_t.size()); end
        checks++; if (n_wready != 3) begin errors++; $display("FAIL err_wready: got %0d expected 3", n_wready); end
        while (exp_hw.size() > 0) begin
            e = exp_hw.pop_front();
            a = act_hw.size() > 0 ? act_hw.pop_front() : 'x;
            checks++; if (a !== e) begin errors++; $display("FAIL err_hwdata: got %h expected %h", a, e); end
        end
        cfg(32'h100, 1'b0, 3'd2, 3'b000, 5'd0, 32'h0);
        run();
        checks++; if (act_t.size() != 1 || act_a[0] !== 32'h100 || done_e !== 1'b0) begin errors++; $display("FAIL err_recover: got %0d beats @%h err %b expected 1 @100 err 0", act_t.size(), act_a[0], done_e); end
        checks++; if (act_rd.size() != 1 || act_rd[0] !== exp_rd[0]) begin errors++; $display("FAIL err_recover_rd: got %h expected %h", act_rd[0], exp_rd[0]); end
    endtask

    task automatic test_back_to_back();
        cfg(32'h200, 1'b0, 3'd2, 3'b000, 5'd0, 32'h0);
        run();
        checks++; if (rdy_at_done !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", rdy_at_done); end
        cfg(32'h300, 1'b0, 3'd2, 3'b001, 5'd0, 32'h0);
        run();
        checks++; if (ix_nonseq != 0) begin errors++; $display("FAIL b2b_nonseq: got cycle %0d expected 0", ix_nonseq); end
        checks++; if (act_t.size() != 1 || act_a[0] !== 32'h300) begin errors++; $display("FAIL b2b_len0: got %0d beats @%h expected 1 @300", act_t.size(), act_a[0]); end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        cmd_addr = 32'h500; cmd_write = 1'b0; cmd_size = 3'd2; cmd_burst = 3'b101; cmd_valid = 1'b1;
        HREADY = 1'b1; HRESP = 2'b00;
        @(posedge HCLK); #1 cmd_valid = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        checks++; if (HTRANS !== 2'b11) begin errors++; $display("FAIL mid_busy: got %b expected 11", HTRANS); end
        HRESETn = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b00 || HADDR !== '0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset: got %b@%h rdy %b expected 00@0 rdy 1", HTRANS, HADDR, cmd_ready); end
        @(posedge HCLK); #1 HRESETn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge HCLK); #2;
            if (done) n_done++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", n_done); end
    endtask

    initial begin
        repeat (3) @(posedge HCLK);
        #1;
        test_reset();
        HRESETn = 1'b1;
        test_single_write();
        test_incr4_write_busy();
        test_wrap8_read();
        test_incr4_read_stall();
        test_incr_1kb();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
